// File: rtl/bias_add_stream_pkg.sv
// Shared constants and arithmetic helpers for the bias-add stream stage.
// Helpers work on 64-bit signed values; callers size-cast results to their own widths.
package bias_add_stream_pkg;

  localparam int DEF_NUM_CH = 128;
  localparam int DEF_BIAS_W = 16;

  // Sign-magnitude word of width w (MSB = sign) to two's complement; -0 maps to 0.
  function automatic logic signed [63:0] sm_to_tc(input logic [63:0] sm, input int w);
    logic [63:0] mag;
    mag = sm & ((64'd1 << (w - 1)) - 64'd1);
    return sm[w-1] ? -$signed(mag) : $signed(mag);
  endfunction

  function automatic logic signed [63:0] sat_hi(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_lo(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  function automatic logic overflows(input logic signed [63:0] v, input int w);
    return (v > sat_hi(w)) || (v < sat_lo(w));
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    if (v > sat_hi(w)) return sat_hi(w);
    if (v < sat_lo(w)) return sat_lo(w);
    return v;
  endfunction

endpackage

// File: rtl/bias_add_stream_table_rf.sv
// Writable per-channel bias register file: one write port, one combinational read port.
// Same depth/width contract as the per-layer bias ROM so ROM contents can be preloaded.
module bias_table_rf
  import bias_add_stream_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int BIAS_W = DEF_BIAS_W,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_addr,
  input  logic [BIAS_W-1:0] wr_data,
  input  logic [CH_W-1:0]   rd_addr,
  output logic [BIAS_W-1:0] rd_data
);

  logic [BIAS_W-1:0] mem [NUM_CH];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem[gi] <= '0;
        end else if (wr_en && (wr_addr == CH_W'(gi))) begin
          mem[gi] <= wr_data;
        end
      end
    end
  endgenerate

  // Read in the write cycle sees the pre-write contents.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/bias_add_stream.sv
// Adds a per-channel sign-magnitude bias to a stream of accumulator beats, then
// rescales, saturates and optionally ReLU-clips. Two-stage pipeline with one shared enable.
module bias_add_stream
  import bias_add_stream_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int BIAS_W     = DEF_BIAS_W,
  parameter int ACC_W      = 24,
  parameter int OUT_W      = 16,
  parameter int BIAS_SHIFT = 0,
  parameter int OUT_SHIFT  = 0,
  parameter int CH_W       = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              relu_en,
  input  logic              bias_wr_en,
  input  logic [CH_W-1:0]   bias_wr_addr,
  input  logic [BIAS_W-1:0] bias_wr_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_first,
  input  logic [ACC_W-1:0]  in_acc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_last,
  output logic              sat_flag
);

  localparam int SUM_W = ACC_W + 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  logic                    en;
  logic                    accept;
  logic [CH_W-1:0]         ch_cnt;
  logic [CH_W-1:0]         in_ch;
  logic [BIAS_W-1:0]       bias_raw;
  logic signed [SUM_W-1:0] bias_al;
  logic signed [SUM_W-1:0] sum;

  logic                    s1_valid;
  logic signed [SUM_W-1:0] s1_sum;
  logic [CH_W-1:0]         s1_ch;

  logic signed [SUM_W-1:0] scaled;
  logic                    sat_hit;
  logic [OUT_W-1:0]        sat_val;
  logic [OUT_W-1:0]        res;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;
  assign in_ch    = in_first ? '0 : ch_cnt;

  bias_table_rf #(
    .NUM_CH (NUM_CH),
    .BIAS_W (BIAS_W),
    .CH_W   (CH_W)
  ) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (bias_wr_en),
    .wr_addr (bias_wr_addr),
    .wr_data (bias_wr_data),
    .rd_addr (in_ch),
    .rd_data (bias_raw)
  );

  // One extra bit of headroom means the add itself can never overflow.
  assign bias_al = SUM_W'(sm_to_tc(64'(bias_raw), BIAS_W)) <<< BIAS_SHIFT;
  assign sum     = SUM_W'($signed(in_acc)) + bias_al;

  assign scaled  = s1_sum >>> OUT_SHIFT;
  assign sat_hit = overflows(64'(scaled), OUT_W);
  assign sat_val = OUT_W'(saturate(64'(scaled), OUT_W));
  assign res     = (relu_en && sat_val[OUT_W-1]) ? '0 : sat_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_cnt    <= '0;
      s1_valid  <= 1'b0;
      s1_sum    <= '0;
      s1_ch     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      if (accept) begin
        ch_cnt <= (in_ch == LAST_CH) ? '0 : in_ch + CH_W'(1);
      end
      if (en) begin
        s1_valid  <= in_valid;
        if (accept) begin
          s1_sum <= sum;
          s1_ch  <= in_ch;
        end
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= res;
          out_ch   <= s1_ch;
          out_last <= (s1_ch == LAST_CH);
          if (sat_hit) sat_flag <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bias_add_stream.sv
// Scoreboard bench for bias_add_stream: the driver pushes hand-computed expectations,
// a forked monitor pops and compares on every output handshake.
module tb_bias_add_stream;

  logic        clk;
  logic        rst_n;
  logic        relu_en;
  logic        bias_wr_en;
  logic [6:0]  bias_wr_addr;
  logic [15:0] bias_wr_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_first;
  logic [23:0] in_acc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [6:0]  out_ch;
  logic        out_last;
  logic        sat_flag;

  typedef struct {
    logic [15:0] data;
    logic [6:0]  ch;
    logic        last;
  } exp_t;

  exp_t sbq[$];
  int   checks;
  int   failures;
  int   tb_bias[128];

  bias_add_stream dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .relu_en      (relu_en),
    .bias_wr_en   (bias_wr_en),
    .bias_wr_addr (bias_wr_addr),
    .bias_wr_data (bias_wr_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_first     (in_first),
    .in_acc       (in_acc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_ch       (out_ch),
    .out_last     (out_last),
    .sat_flag     (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic monitor();
    logic        hold_pending;
    logic [15:0] hd;
    logic [6:0]  hc;
    exp_t        e;
    hold_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_pending = 1'b0;
      end else begin
        if (hold_pending) begin
          chk("hold_data", 32'(out_data), 32'(hd));
          chk("hold_ch", 32'(out_ch), 32'(hc));
        end
        hold_pending = out_valid && !out_ready;
        hd = out_data;
        hc = out_ch;
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out actual=ch%0d/0x%0h required=none", out_ch, out_data);
          end else begin
            e = sbq.pop_front();
            $display("out ch=%0d data=0x%04h last=%0b (exp ch=%0d data=0x%04h)",
                     out_ch, out_data, out_last, e.ch, e.data);
            chk("out_data", 32'(out_data), 32'(e.data));
            chk("out_ch", 32'(out_ch), 32'(e.ch));
            chk("out_last", 32'(out_last), 32'(e.last));
          end
        end
      end
    end
  endtask

  task automatic wr(input logic [6:0] addr, input logic [15:0] data);
    bias_wr_en   = 1'b1;
    bias_wr_addr = addr;
    bias_wr_data = data;
    @(posedge clk);
    #1;
    bias_wr_en = 1'b0;
  endtask

  // Presents one beat and waits (bounded) for it to be accepted.
  task automatic send(input logic [23:0] acc, input logic first,
                      input logic [15:0] exp_data, input logic [6:0] exp_ch);
    int   n;
    logic ok;
    exp_t e;
    in_valid = 1'b1;
    in_acc   = acc;
    in_first = first;
    n = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted acc=0x%0h", acc);
    end else begin
      e.data = exp_data;
      e.ch   = exp_ch;
      e.last = (exp_ch == 7'd127);
      sbq.push_back(e);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(sbq.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    checks = 0;
    failures = 0;
    foreach (tb_bias[i]) tb_bias[i] = 0;
    rst_n = 1'b0;
    relu_en = 1'b0;
    bias_wr_en = 1'b0;
    bias_wr_addr = '0;
    bias_wr_data = '0;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_acc = '0;
    out_ready = 1'b1;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_sat_flag", 32'(sat_flag), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic bias add and latency; negative-zero bias
    wr(7'd1, 16'h8019); tb_bias[1] = -25;
    wr(7'd5, 16'h8000);
    send(24'd100, 1'b1, 16'd100, 7'd0);
    chk("lat_not_yet", 32'(out_valid), 32'd0);
    send(24'd100, 1'b0, 16'd75, 7'd1);
    chk("lat_two_cycles", 32'(out_valid), 32'd1);
    // Write in the same cycle as the ch2 read: ch2 still sees the old 0.
    bias_wr_en = 1'b1; bias_wr_addr = 7'd2; bias_wr_data = 16'h0005;
    send(24'd10, 1'b0, 16'd10, 7'd2);
    bias_wr_en = 1'b0; tb_bias[2] = 5;
    send(24'd0, 1'b0, 16'd0, 7'd3);
    send(24'd0, 1'b0, 16'd0, 7'd4);
    send(24'hFFFFF9, 1'b0, 16'hFFF9, 7'd5);
    idle();
    drain();
    chk("negzero_sat_flag", 32'(sat_flag), 32'd0);

    // Positive saturation, ReLU, negative saturation
    wr(7'd0, 16'h0001); tb_bias[0] = 1;
    send(24'h7FFFFF, 1'b1, 16'h7FFF, 7'd0);
    idle();
    drain();
    chk("sat_set", 32'(sat_flag), 32'd1);
    relu_en = 1'b1;
    send(24'hFFFED4, 1'b1, 16'h0000, 7'd0);
    send(24'd50, 1'b0, 16'd25, 7'd1);
    idle();
    drain();
    chk("sat_sticky", 32'(sat_flag), 32'd1);
    relu_en = 1'b0;
    send(24'h800000, 1'b1, 16'h8000, 7'd0);
    idle();
    drain();

    // 130-beat stream with wrap
    for (int i = 0; i < 130; i++) begin
      send(24'(i * 2), (i == 0), 16'(i * 2 + tb_bias[i % 128]), 7'(i % 128));
    end
    idle();
    drain();

    // Backpressure: out_ready low for 5 cycles while beats are offered
    out_ready = 1'b0;
    fork
      begin
        send(24'd1000, 1'b1, 16'd1001, 7'd0);
        send(24'd1000, 1'b0, 16'd975, 7'd1);
        send(24'd1002, 1'b0, 16'd1007, 7'd2);
        send(24'd1003, 1'b0, 16'd1003, 7'd3);
        send(24'd1004, 1'b0, 16'd1004, 7'd4);
        send(24'd1005, 1'b0, 16'd1005, 7'd5);
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with two beats in flight
    send(24'd10, 1'b1, 16'd11, 7'd0);
    send(24'd20, 1'b0, 16'hFFFB, 7'd1);
    idle();
    rst_n = 1'b0;
    #1;
    sbq.delete();
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_sat_flag", 32'(sat_flag), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    foreach (tb_bias[i]) tb_bias[i] = 0;
    @(posedge clk);
    #1;
    send(24'd10, 1'b0, 16'd10, 7'd0);
    send(24'd10, 1'b0, 16'd10, 7'd1);
    relu_en = 1'b1;
    send(24'hFFFFFB, 1'b0, 16'd0, 7'd2);
    idle();
    drain();
    chk("relu_not_sat", 32'(sat_flag), 32'd0);
    relu_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
